// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule state encoding, round constants and the S-box.
// Used by the key expander and the SubBytes datapath.
package aes_pkg;

    localparam int AES_NR     = 10;
    localparam int AES_NWORDS = 4 * (AES_NR + 1);

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_LOAD   = 2'd1,
        KS_EXPAND = 2'd2,
        KS_DONE   = 2'd3
    } key_exp_state_t;

    // Indexed by word index bits [5:2]; entry 0 and 11..15 are never selected during expansion.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] aes_sbox_f(input logic [7:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational AES SubWord: S-box substitution applied independently to each byte of a word.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign o_word[8*gi +: 8] = aes_sbox_f(i_word[8*gi +: 8]);
    end

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key schedule: loads four key words, then generates w[4..43] one word per clock.
// Build option AES_KEY_REUSE_EN skips re-expansion when an identical key is reloaded.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NR     = AES_NR,
    parameter int NWORDS = AES_NWORDS
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        key_start,
    input  logic [31:0] key_word_in,
    input  logic [3:0]  rk_round,
    input  logic [1:0]  rk_col,
    output logic [31:0] rk_word,
    output logic        key_expand_done,
    output logic        busy,
    output logic [5:0]  dbg_word_idx
);

    key_exp_state_t r_state, w_state_next;
    logic [5:0]     r_idx, w_idx_next;
    logic           r_done, w_done_next;
    logic           r_busy, w_busy_next;
    logic [31:0]    r_words [NWORDS];

    logic           w_we;
    logic [5:0]     w_waddr;
    logic [31:0]    w_wdata;

    logic [31:0]    w_prev, w_back4, w_rot, w_sub, w_temp, w_expand;
    logic [5:0]     w_rk_idx;

`ifdef AES_KEY_REUSE_EN
    logic           r_match, w_match_next;
    logic           r_valid, w_valid_next;
    logic           w_word_eq, w_word0_eq;

    assign w_word_eq  = (key_word_in == r_words[r_idx]);
    assign w_word0_eq = (key_word_in == r_words[0]);
`endif

    // Expansion datapath for the word currently being written
    assign w_prev   = r_words[r_idx - 6'd1];
    assign w_back4  = r_words[r_idx - 6'd4];
    assign w_rot    = {w_prev[23:0], w_prev[31:24]};

    aes_subword u_subword (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    assign w_temp   = (r_idx[1:0] == 2'd0) ? (w_sub ^ {RCON[r_idx[5:2]], 24'h0}) : w_prev;
    assign w_expand = w_back4 ^ w_temp;

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_done_next  = r_done;
        // busy is registered, so it stays up for the first DONE cycle as well
        w_busy_next  = (r_state == KS_LOAD) || (r_state == KS_EXPAND);
        w_we         = 1'b0;
        w_waddr      = r_idx;
        w_wdata      = key_word_in;
`ifdef AES_KEY_REUSE_EN
        w_match_next = r_match;
        w_valid_next = r_valid;
`endif
        if (key_start) begin
            w_we         = 1'b1;
            w_waddr      = 6'd0;
            w_state_next = KS_LOAD;
            w_idx_next   = 6'd1;
            w_done_next  = 1'b0;
            w_busy_next  = 1'b1;
`ifdef AES_KEY_REUSE_EN
            w_match_next = w_word0_eq;
            if ((r_state == KS_LOAD) || (r_state == KS_EXPAND)) begin
                w_valid_next = 1'b0;
            end
`endif
        end else begin
            case (r_state)
                KS_LOAD: begin
                    w_we       = 1'b1;
                    w_idx_next = r_idx + 6'd1;
`ifdef AES_KEY_REUSE_EN
                    w_match_next = r_match & w_word_eq;
`endif
                    if (r_idx == 6'd3) begin
                        w_state_next = KS_EXPAND;
`ifdef AES_KEY_REUSE_EN
                        if (r_valid && r_match && w_word_eq) begin
                            w_state_next = KS_DONE;
                            w_done_next  = 1'b1;
                            w_idx_next   = r_idx;
                        end
`endif
                    end
                end
                KS_EXPAND: begin
                    w_we    = 1'b1;
                    w_wdata = w_expand;
                    if (r_idx == 6'(NWORDS - 1)) begin
                        w_state_next = KS_DONE;
                        w_done_next  = 1'b1;
`ifdef AES_KEY_REUSE_EN
                        w_valid_next = 1'b1;
`endif
                    end else begin
                        w_idx_next = r_idx + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= KS_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef AES_KEY_REUSE_EN
            r_match <= 1'b0;
            r_valid <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_done  <= w_done_next;
            r_busy  <= w_busy_next;
`ifdef AES_KEY_REUSE_EN
            r_match <= w_match_next;
            r_valid <= w_valid_next;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NWORDS; k++) begin
                r_words[k] <= '0;
            end
        end else if (w_we) begin
            r_words[w_waddr] <= w_wdata;
        end
    end

    assign w_rk_idx        = {rk_round, 2'b00} + {4'b0000, rk_col};
    assign rk_word         = (rk_round > 4'(NR)) ? 32'h0 : r_words[w_rk_idx];
    assign key_expand_done = r_done;
    assign busy            = r_busy;
    assign dbg_word_idx    = r_idx;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: per-cycle comparison against a key-schedule model
// built from GF(2^8) arithmetic, plus FIPS-197 literal vectors.
module tb_aes_key_expander;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        key_start = 1'b0;
    logic [31:0] key_word_in = '0;
    logic [3:0]  rk_round = '0;
    logic [1:0]  rk_col = '0;
    logic [31:0] rk_word;
    logic        key_expand_done;
    logic        busy;
    logic [5:0]  dbg_word_idx;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    aes_key_expander dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .key_start       (key_start),
        .key_word_in     (key_word_in),
        .rk_round        (rk_round),
        .rk_col          (rk_col),
        .rk_word         (rk_word),
        .key_expand_done (key_expand_done),
        .busy            (busy),
        .dbg_word_idx    (dbg_word_idx)
    );

    logic [31:0] KEY_FIPS [4] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
    logic [31:0] KEY_ZERO [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] KEY_SEQ  [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    logic [31:0] KEY_MOD  [4] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71589, 32'h09cf4f3c};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // GF(2^8) arithmetic for an S-box derived from first principles
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 0; k < 254; k++) r = gmul(r, a);
        return r ^ rl(r, 1) ^ rl(r, 2) ^ rl(r, 3) ^ rl(r, 4) ^ 8'h63;
    endfunction

    // Behavioural model state
    logic [31:0] m_sched [44];
    logic [31:0] m_key   [4];
    logic [31:0] m_new   [4];
    bit          m_started, m_valid;
    int          m_age, m_len;

    task automatic model_expand(input logic [31:0] k [4]);
        logic [7:0]  rc;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) m_sched[i] = k[i];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = m_sched[i-1];
            if (i % 4 == 0) begin
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            m_sched[i] = m_sched[i-4] ^ t;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 44; i++) m_sched[i] = '0;
        for (int i = 0; i < 4; i++) begin m_key[i] = '0; m_new[i] = '0; end
        m_started = 0; m_valid = 0; m_age = 0; m_len = 44;
    endtask

    task automatic model_check();
        bit          e_busy, e_done;
        logic [31:0] e_idx;
        int          ix;
        e_busy = m_started && (m_age >= 1) && (m_age <= m_len);
        e_done = m_started && (m_age >= m_len);
        if (!m_started)          e_idx = 32'd0;
        else if (m_age < m_len)  e_idx = 32'(m_age);
        else                     e_idx = (m_len == 44) ? 32'd43 : 32'd3;
        chk("busy", {31'b0, busy}, {31'b0, e_busy});
        chk("done", {31'b0, key_expand_done}, {31'b0, e_done});
        chk("word_idx", {26'b0, dbg_word_idx}, e_idx);
        ix = 4 * int'(rk_round) + int'(rk_col);
        if (rk_round > 4'd10)            chk("rk_oob", rk_word, 32'h0);
        else if (e_done || !m_started)   chk("rk_word", rk_word, m_sched[ix]);
    endtask

    task automatic model_advance();
        bit same;
        if (key_start) begin
            if (m_started && m_age >= 1 && m_age < m_len) m_valid = 0;
            m_started = 1; m_age = 1; m_len = 44;
            m_new[0] = key_word_in;
        end else if (m_started) begin
            if (m_age >= 1 && m_age <= 3) m_new[m_age] = key_word_in;
            if (m_age == 3) begin
                same = 1;
                for (int i = 0; i < 4; i++) if (m_new[i] !== m_key[i]) same = 0;
`ifdef AES_KEY_REUSE_EN
                if (m_valid && same) m_len = 4;
`endif
                m_key = m_new;
                model_expand(m_new);
            end
            if (m_age < 1000) m_age++;
            if (m_age == 44 && m_len == 44) m_valid = 1;
        end
    endtask

    // Compare outputs mid-cycle, then apply the inputs the coming edge will sample
    initial begin
        model_reset();
        forever begin
            @(negedge clock);
            if (!reset_n) model_reset();
            model_check();
            if (reset_n) model_advance();
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_partial(input logic [31:0] k [4], input int stop);
        step();
        key_start = 1'b1;
        key_word_in = k[0];
        for (int j = 1; j <= stop; j++) begin
            step();
            key_start = 1'b0;
            key_word_in = (j <= 3) ? k[j] : $urandom;
            rk_round = 4'($urandom_range(0, 15));
            rk_col = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic drive_key(input logic [31:0] k [4], input int exp_cyc, input string name);
        int c;
        load_partial(k, 3);
        c = 3;
        while (!key_expand_done && c < 80) begin
            step();
            c++;
            key_word_in = $urandom;
        end
        $display("load %s: key %h.. done after %0d cycles", name, k[0], c);
        chk({name, "_latency"}, 32'(c), 32'(exp_cyc));
    endtask

    task automatic read_chk(input int r, input int c, input logic [31:0] exp, input string name);
        rk_round = 4'(r);
        rk_col = 2'(c);
        #1;
        chk(name, rk_word, exp);
    endtask

    task automatic sweep();
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 4; c++) begin
                rk_round = 4'(r);
                rk_col = 2'(c);
                step();
            end
        end
    endtask

    initial begin
        #2;
        chk("reset_done", {31'b0, key_expand_done}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_idx", {26'b0, dbg_word_idx}, 32'h0);
        chk("reset_rk", rk_word, 32'h0);
        step(); step();
        reset_n = 1'b1;
        step();

        drive_key(KEY_FIPS, 44, "fips");
        step();
        chk("model_w4", m_sched[4], 32'ha0fafe17);
        read_chk(1, 0, 32'ha0fafe17, "fips_w4");
        read_chk(10, 0, 32'hd014f9a8, "fips_r10c0");
        read_chk(10, 1, 32'hc9ee2589, "fips_r10c1");
        read_chk(10, 2, 32'he13f0cc8, "fips_r10c2");
        read_chk(10, 3, 32'hb6630ca6, "fips_r10c3");
        for (int r = 11; r < 16; r++) begin
            step();
            read_chk(r, r % 4, 32'h0, "rk_round_gt10");
        end
        sweep();

        drive_key(KEY_ZERO, 44, "zero");
        step();
        for (int c = 0; c < 4; c++) read_chk(1, c, 32'h62636363, "zero_r1");
        read_chk(10, 0, 32'hb4ef5bcb, "zero_r10c0");

        // Abort at i=20 and restart with another key
        load_partial(KEY_FIPS, 19);
        drive_key(KEY_SEQ, 44, "abort_restart");
        step();
        read_chk(10, 0, 32'h13111d7f, "seq_r10c0");
        read_chk(10, 3, 32'h4d2b30c5, "seq_r10c3");
        sweep();

        // Reset mid-expansion
        load_partial(KEY_FIPS, 30);
        reset_n = 1'b0;
        #1;
        chk("midreset_done", {31'b0, key_expand_done}, 32'h0);
        chk("midreset_busy", {31'b0, busy}, 32'h0);
        step(); step();
        reset_n = 1'b1;
        sweep();
        drive_key(KEY_FIPS, 44, "after_reset");
        step();
        read_chk(10, 3, 32'hb6630ca6, "after_reset_r10c3");

`ifdef AES_KEY_REUSE_EN
        drive_key(KEY_FIPS, 4, "fips_reload");
`else
        drive_key(KEY_FIPS, 44, "fips_reload");
`endif
        step();
        read_chk(10, 0, 32'hd014f9a8, "reload_r10c0");
        drive_key(KEY_MOD, 44, "mod_word2");
        sweep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Sequential AES-128 key-schedule engine that sits beside the encryption state-sequencing FSM. It captures the 128-bit cipher key as four 32-bit words, generates round-key words w[4]..w[43] one word per clock, and holds all 44 words in an internal register file. It signals completion with `key_expand_done` and serves round-key words to the AddRoundKey datapath through a combinational read port.

## Interface
Parameters:
- `NR`, 10, number of AES rounds; fixed for AES-128, not user-varied.
- `NWORDS`, 44, round-key words stored, equal to 4*(NR+1).

Ports:
- `clock`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `key_start`  in  1  single-cycle pulse; the same cycle carries key word 0 on `key_word_in`.
- `key_word_in`  in  32  key word; byte 0 is bits [31:24].
- `rk_round`  in  4  round-key select, 0..10.
- `rk_col`  in  2  column (word) within the round key.
- `rk_word`  out  32  combinational read, equal to w[4*rk_round + rk_col].
- `key_expand_done`  out  1  level signal; high while a complete schedule is held.
- `busy`  out  1  high in LOAD and EXPAND.
- `dbg_word_idx`  out  6  current write index i.

## Operation
- States:
  - IDLE (encoding 0).
  - LOAD (1).
  - EXPAND (2).
  - DONE (3).
- IDLE or DONE + `key_start`:
  - write `key_word_in` to w[0].
  - set load counter to 1 and go to LOAD.
  - clear `key_expand_done`.
- LOAD:
  - each cycle, write `key_word_in` to w[cnt] and increment cnt.
  - after w[3] is written, set i=4 and go to EXPAND.
- EXPAND, one word per cycle:
  - temp = w[i-1].
  - if i%4==0: temp = SubWord(RotWord(temp)) ^ {rcon[i/4], 24'h0}.
  - w[i] = w[i-4] ^ temp.
  - after i=43 is written, go to DONE.
- RotWord rotates left by one byte. SubWord applies the AES S-box to each byte.
- rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. rcon is indexed by i[5:2].
- DONE: `key_expand_done`=1 and the register file is frozen until the next `key_start`.
- `key_start` in LOAD or EXPAND: abort the current operation, treat the cycle as word 0 of a new key, and restart LOAD. No partial done pulse is produced.
- Read port with `rk_round` > 10: `rk_word`=0.
- Reads during LOAD or EXPAND return the current register contents; they are valid only when `key_expand_done`=1.
- All index arithmetic is 6-bit unsigned. i never exceeds 43.

## Timing
- Reset values:
  - state=IDLE.
  - `key_expand_done`=0.
  - `busy`=0.
  - `dbg_word_idx`=0.
  - all 44 words = 32'h0.
- Key words are accepted on 4 consecutive cycles T..T+3, where T is the `key_start` cycle. There is no stall.
- EXPAND writes occupy cycles T+4..T+43.
- `key_expand_done` rises at T+44 (registered) and stays high until the cycle after the next `key_start`.
- `busy` is high from T+1 through T+44 inclusive.
- `rk_word` is valid in the same cycle as `rk_round`/`rk_col` change (zero-cycle read latency).
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously).

## Configuration
- Macro `AES_KEY_REUSE_EN`.
- Defined:
  - during LOAD, each incoming word is compared with the stored w[k] before it is overwritten, and a match flag is kept.
  - if all four words match and a previous schedule completed (valid flag), the block goes LOAD→DONE after word 3.
  - in that case `key_expand_done` rises at T+4 and words w[4..43] are untouched.
  - the valid flag is cleared by reset and by an aborted expansion.
- Undefined: every `key_start` triggers a full 40-cycle expansion.

## Structure
- Shared package `aes_pkg` holds:
  - state enum `key_exp_state_t`.
  - `RCON` constant array.
  - `AES_NR` and `AES_NWORDS` constants.
  - S-box table function `aes_sbox_f`, shared with the SubBytes datapath.
- One sub-module, `aes_subword`: 32-bit combinational SubWord built from four S-box lookups. It is instantiated once.
- Register file: a 44x32 flop array inside `aes_key_expander`.

## Test plan
- FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c:
  - w[4]=a0fafe17.
  - round 10 reads d014f9a8, c9ee2589, e13f0cc8, b6630ca6.
  - `key_expand_done` rises exactly 44 cycles after `key_start`.
- All-zero key:
  - round 1 = 62636363 62636363 62636363 62636363.
  - round 10 col 0 = b4ef5bcb.
- `key_start` at EXPAND i=20 with the FIPS key:
  - done stays 0.
  - new expansion completes 44 cycles after the second `key_start`.
  - results are correct for the new key.
- `reset_n` low at T+30:
  - done=0, busy=0, all reads=0.
  - next full key load is correct.
- `rk_round`=11..15 in DONE → `rk_word`=0.
- With `AES_KEY_REUSE_EN`, load the FIPS key twice:
  - second load: done at T+4, and busy spans only T+1..T+4.
  - changing one byte of word 2 forces a full 44-cycle expansion.
